// File: rtl/motion_executor_pkg.sv
// Shared motion-interface encoding: command fields, opcodes, FSM states.
package motion_executor_pkg;

  localparam int unsigned CMD_W   = 10;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned MAG_W   = 8;
  localparam int unsigned SPEED_W = 3;
  localparam int unsigned PWM_W   = 3;

  localparam int unsigned CMD_OP_MSB  = 9;
  localparam int unsigned CMD_OP_LSB  = 8;
  localparam int unsigned CMD_MAG_MSB = 7;
  localparam int unsigned CMD_MAG_LSB = 0;

  localparam logic [OP_W-1:0] OP_STOP   = 2'b00;
  localparam logic [OP_W-1:0] OP_FWD    = 2'b01;
  localparam logic [OP_W-1:0] OP_SPIN_L = 2'b10;
  localparam logic [OP_W-1:0] OP_SPIN_R = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [MAG_W-1:0] mag;
  } motion_cmd_t;

  // Build a command word from its opcode and magnitude fields.
  function automatic motion_cmd_t make_cmd(input logic [OP_W-1:0] op,
                                           input logic [MAG_W-1:0] mag);
    motion_cmd_t c;
    c.op  = op;
    c.mag = mag;
    return c;
  endfunction

endpackage

// File: rtl/motion_executor_if.sv
// Motion interface between the command generator and the executor.
interface motion_executor_if;
  import motion_executor_pkg::*;

  logic               enable;
  logic [CMD_W-1:0]   motion_command;
  logic [SPEED_W-1:0] output_speed;
  logic               left_pwm;
  logic               right_pwm;
  logic               left_dir;
  logic               right_dir;
  logic               busy;
  logic               done_spin;

  modport master (
    output enable, motion_command, output_speed,
    input  left_pwm, right_pwm, left_dir, right_dir, busy, done_spin
  );

  modport slave (
    input  enable, motion_command, output_speed,
    output left_pwm, right_pwm, left_dir, right_dir, busy, done_spin
  );

endinterface

// File: rtl/motion_executor_motor_pwm.sv
// Per-wheel PWM: 3-bit counter that runs only in RUN, registered compare output.
module motor_pwm
  import motion_executor_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               run_cur,
  input  logic               run_nxt,
  input  logic [SPEED_W-1:0] speed,
  output logic               pwm
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] cnt_nxt;

  // Counter restarts on RUN entry so the output lines up with busy
  always_comb begin
    cnt_nxt = '0;
    if (run_cur && run_nxt) begin
      cnt_nxt = cnt + PWM_W'(1);
    end
  end

  // Counter and registered duty compare
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
      pwm <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      pwm <= run_nxt && (cnt_nxt < speed);
    end
  end

endmodule

// File: rtl/motion_executor.sv
// Motion executor: latches a command, drives the wheels and reports completion.
module motion_executor
  import motion_executor_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50,
  parameter int unsigned ACC_W    = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  motion_executor_if.slave        bus
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  state_t           state;
  state_t           state_nxt;
  motion_cmd_t      cmd_q;
  motion_cmd_t      cmd_nxt;
  motion_cmd_t      cmd_in;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W-1:0] acc_sat;
  logic [SUM_W-1:0] acc_sum;
  logic [PRE_W-1:0] presc;
  logic [PRE_W-1:0] presc_nxt;
  logic             run_cur;
  logic             run_nxt;
  logic             busy_q;
  logic             done_q;
  logic             left_dir_q;
  logic             right_dir_q;
  logic             left_pwm_q;
  logic             right_pwm_q;

  assign cmd_in.op  = bus.motion_command[CMD_OP_MSB:CMD_OP_LSB];
  assign cmd_in.mag = bus.motion_command[CMD_MAG_MSB:CMD_MAG_LSB];

  // Saturating progress increment by the current speed
  always_comb begin
    acc_sum = {1'b0, acc} + SUM_W'(bus.output_speed);
    acc_sat = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
  end

  // Next-state and datapath updates; abort on enable low beats completion
  always_comb begin
    state_nxt = state;
    cmd_nxt   = cmd_q;
    acc_nxt   = acc;
    presc_nxt = presc;
    case (state)
      ST_IDLE: begin
        if (bus.enable && (cmd_in.op != OP_STOP)) begin
          state_nxt = ST_RUN;
          cmd_nxt   = cmd_in;
          acc_nxt   = '0;
          presc_nxt = '0;
        end
      end
      ST_RUN: begin
        if (!bus.enable) begin
          state_nxt = ST_IDLE;
        end else if (acc >= ACC_W'(cmd_q.mag)) begin
          state_nxt = ST_DONE;
        end
        if (presc == PRE_LAST) begin
          presc_nxt = '0;
          acc_nxt   = acc_sat;
        end else begin
          presc_nxt = presc + PRE_W'(1);
        end
      end
      ST_DONE: begin
        if (!bus.enable || (cmd_in != cmd_q)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      cmd_q <= '0;
      acc   <= '0;
      presc <= '0;
    end else begin
      state <= state_nxt;
      cmd_q <= cmd_nxt;
      acc   <= acc_nxt;
      presc <= presc_nxt;
    end
  end

  assign run_cur = (state == ST_RUN);
  assign run_nxt = (state_nxt == ST_RUN);

  // Status and direction outputs registered from the upcoming state
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      left_dir_q  <= 1'b0;
      right_dir_q <= 1'b0;
    end else begin
      busy_q      <= run_nxt;
      done_q      <= (state_nxt == ST_DONE);
      left_dir_q  <= run_nxt && ((cmd_nxt.op == OP_FWD) || (cmd_nxt.op == OP_SPIN_R));
      right_dir_q <= run_nxt && ((cmd_nxt.op == OP_FWD) || (cmd_nxt.op == OP_SPIN_L));
    end
  end

  motor_pwm u_left_pwm (
    .clk     (clk),
    .rst     (rst),
    .run_cur (run_cur),
    .run_nxt (run_nxt),
    .speed   (bus.output_speed),
    .pwm     (left_pwm_q)
  );

  motor_pwm u_right_pwm (
    .clk     (clk),
    .rst     (rst),
    .run_cur (run_cur),
    .run_nxt (run_nxt),
    .speed   (bus.output_speed),
    .pwm     (right_pwm_q)
  );

  assign bus.busy      = busy_q;
  assign bus.done_spin = done_q;
  assign bus.left_dir  = left_dir_q;
  assign bus.right_dir = right_dir_q;
  assign bus.left_pwm  = left_pwm_q;
  assign bus.right_pwm = right_pwm_q;

endmodule

// File: tb/tb_motion_executor.sv
// Bench for motion_executor: directed vector table, corner sequences, randomized runs.
module tb_motion_executor;
  import motion_executor_pkg::*;

  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  motion_executor_if mif ();

  motion_executor #(.TICK_DIV(TD), .ACC_W(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] mag;
    logic [2:0] spd;
    int         cycles;
    logic       ldir;
    logic       rdir;
  } vec_t;

  vec_t vec [8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag, input int exp_done);
    check({tag, "_busy"}, int'(mif.busy), 0);
    check({tag, "_done"}, int'(mif.done_spin), exp_done);
    check({tag, "_lpwm"}, int'(mif.left_pwm), 0);
    check({tag, "_rpwm"}, int'(mif.right_pwm), 0);
    check({tag, "_ldir"}, int'(mif.left_dir), 0);
    check({tag, "_rdir"}, int'(mif.right_dir), 0);
  endtask

  // Launch a command from IDLE and check each RUN cycle against a progress model.
  // mode: 0 constant speed, 1 random speed each cycle, 2 zero for 40 cycles then 3.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] mag, input int mode,
                         input logic [2:0] sp0, input int abort_at,
                         input logic [9:0] alt_cmd, input int alt_at);
    int         acc_m;
    int         i;
    bit         fin;
    bit         aborted;
    logic [2:0] sp_prev;
    logic [2:0] sp_new;
    int         exp_l;
    int         exp_r;
    exp_l = (op != OP_SPIN_L) ? 1 : 0;
    exp_r = (op != OP_SPIN_R) ? 1 : 0;
    mif.motion_command = make_cmd(op, mag);
    mif.output_speed   = sp0;
    mif.enable         = 1'b1;
    sp_prev = sp0;
    acc_m   = 0;
    i       = 0;
    fin     = 1'b0;
    aborted = 1'b0;
    while (!fin) begin
      @(negedge clk);
      check("run_busy", int'(mif.busy), 1);
      check("run_done_low", int'(mif.done_spin), 0);
      check("run_left_dir", int'(mif.left_dir), exp_l);
      check("run_right_dir", int'(mif.right_dir), exp_r);
      check("run_left_pwm", int'(mif.left_pwm), ((i % 8) < int'(sp_prev)) ? 1 : 0);
      check("run_right_pwm", int'(mif.right_pwm), ((i % 8) < int'(sp_prev)) ? 1 : 0);
      case (mode)
        1:       sp_new = 3'($urandom_range(1, 7));
        2:       sp_new = (i >= 39) ? 3'd3 : 3'd0;
        default: sp_new = sp0;
      endcase
      mif.output_speed = sp_new;
      if (i == alt_at) mif.motion_command = alt_cmd;
      if (i == abort_at) begin
        mif.enable = 1'b0;
        aborted    = 1'b1;
        fin        = 1'b1;
      end else if (acc_m >= int'(mag)) begin
        fin = 1'b1;
      end
      if ((i % TD) == (TD - 1)) acc_m = (acc_m + int'(sp_new) > 2047) ? 2047 : acc_m + int'(sp_new);
      sp_prev = sp_new;
      i++;
    end
    @(negedge clk);
    check_quiet("end", aborted ? 0 : 1);
  endtask

  initial begin
    int n;
    int nl;
    int nr;
    logic [1:0] op;
    logic [7:0] mag;
    logic [2:0] sp0;
    int ab;
    int at;
    logic [9:0] alt;

    vec[0] = '{OP_SPIN_L, 8'd8,   3'd4, 9,   1'b0, 1'b1};
    vec[1] = '{OP_FWD,    8'd0,   3'd7, 1,   1'b1, 1'b1};
    vec[2] = '{OP_SPIN_R, 8'd20,  3'd5, 17,  1'b1, 1'b0};
    vec[3] = '{OP_FWD,    8'd10,  3'd3, 17,  1'b1, 1'b1};
    vec[4] = '{OP_SPIN_L, 8'd1,   3'd7, 5,   1'b0, 1'b1};
    vec[5] = '{OP_FWD,    8'd21,  3'd7, 13,  1'b1, 1'b1};
    vec[6] = '{OP_SPIN_R, 8'd255, 3'd7, 149, 1'b1, 1'b0};
    vec[7] = '{OP_FWD,    8'd16,  3'd1, 65,  1'b1, 1'b1};

    // Reset held two clocks with SPIN_L,8 applied
    rst = 1'b0;
    mif.enable = 1'b1;
    mif.motion_command = 10'b10_00001000;
    mif.output_speed = 3'd4;
    repeat (2) @(negedge clk);
    check_quiet("reset", 0);
    rst = 1'b1;

    // Released: SPIN_L,8 at speed 4 runs to completion, done holds
    run_cmd(OP_SPIN_L, 8'd8, 0, 3'd4, -1, 10'd0, -1);
    repeat (3) begin
      @(negedge clk);
      check("done_hold", int'(mif.done_spin), 1);
    end
    mif.motion_command = 10'd0;
    @(negedge clk);
    check_quiet("done_clear", 0);

    // Directed vector table: busy length and directions
    for (int k = 0; k < 8; k++) begin
      mif.motion_command = make_cmd(vec[k].op, vec[k].mag);
      mif.output_speed   = vec[k].spd;
      mif.enable         = 1'b1;
      @(negedge clk);
      check("vec_left_dir", int'(mif.left_dir), int'(vec[k].ldir));
      check("vec_right_dir", int'(mif.right_dir), int'(vec[k].rdir));
      n = 0;
      while ((mif.busy === 1'b1) && (n < 2000)) begin
        n++;
        @(negedge clk);
      end
      check("vec_busy_cycles", n, vec[k].cycles);
      check("vec_done", int'(mif.done_spin), 1);
      mif.motion_command = 10'd0;
      @(negedge clk);
      check("vec_done_clear", int'(mif.done_spin), 0);
    end

    // Duty at speed 7 over 64 RUN cycles
    mif.motion_command = make_cmd(OP_FWD, 8'd255);
    mif.output_speed   = 3'd7;
    mif.enable         = 1'b1;
    nl = 0;
    nr = 0;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      nl += int'(mif.left_pwm);
      nr += int'(mif.right_pwm);
    end
    check("duty_left", nl, 56);
    check("duty_right", nr, 56);
    check("duty_busy", int'(mif.busy), 1);
    mif.enable = 1'b0;
    @(negedge clk);
    check_quiet("duty_abort", 0);

    // Abort SPIN_R,20 after six RUN cycles
    run_cmd(OP_SPIN_R, 8'd20, 0, 3'd5, 5, 10'd0, -1);
    repeat (3) begin
      @(negedge clk);
      check_quiet("abort_after", 0);
    end

    // Enable drop in the completing cycle: abort wins
    run_cmd(OP_SPIN_L, 8'd8, 0, 3'd4, 8, 10'd0, -1);

    // Speed 0 for 40 cycles, then 3
    run_cmd(OP_FWD, 8'd12, 2, 3'd0, -1, 10'd0, -1);
    mif.motion_command = 10'd0;
    @(negedge clk);
    check("spd0_done_clear", int'(mif.done_spin), 0);

    // Command change mid-RUN is ignored, then accepted one cycle after leaving DONE
    run_cmd(OP_SPIN_L, 8'd8, 0, 3'd4, -1, make_cmd(OP_FWD, 8'd200), 3);
    @(negedge clk);
    check_quiet("chg_idle", 0);
    @(negedge clk);
    check("chg_busy", int'(mif.busy), 1);
    check("chg_left_dir", int'(mif.left_dir), 1);
    check("chg_right_dir", int'(mif.right_dir), 1);
    mif.enable = 1'b0;
    @(negedge clk);
    check_quiet("chg_abort", 0);

    // Randomized runs with varying speed, occasional aborts and command changes
    for (int r = 0; r < 25; r++) begin
      op  = 2'($urandom_range(1, 3));
      mag = 8'($urandom_range(0, 80));
      sp0 = 3'($urandom_range(1, 7));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
      at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1;
      alt = 10'($urandom);
      run_cmd(op, mag, 1, sp0, ab, alt, at);
      mif.motion_command = 10'd0;
      mif.enable = 1'b1;
      @(negedge clk);
      check("rnd_idle_busy", int'(mif.busy), 0);
      check("rnd_idle_done", int'(mif.done_spin), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/motion_executor.md
Name: motion_executor

Overview:
- Consumer end of the motion interface driven by spiral_move.
- Accepts the 10-bit motion_command and 3-bit output_speed, drives the left and right wheel PWM and direction signals, and measures progress in timed ticks.
- Returns done_spin to the command generator when the commanded spin or move completes.
- Sits between the behaviour FSMs and the motor pins.

Parameters:
- TICK_DIV, 50: clock cycles per progress tick (prescaler terminal count).
- ACC_W, 11: progress accumulator width. Must be at least 9.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-low reset
- enable  input  1  block enable; low aborts any motion
- motion_command  input  10  [9:8] opcode (00 STOP, 01 FWD, 10 SPIN_L, 11 SPIN_R); [7:0] magnitude in ticks·speed units
- output_speed  input  3  speed level 0..7; sampled every cycle during RUN
- left_pwm  output  1  left motor PWM
- right_pwm  output  1  right motor PWM
- left_dir  output  1  1 = forward
- right_dir  output  1  1 = forward
- busy  output  1  high in RUN
- done_spin  output  1  completion flag, level

Behaviour:
- Reset (rst == 0 at a clock edge): state=IDLE, accumulator=0, prescaler=0, pwm counter=0. All outputs 0. Reset mid-RUN takes effect at that edge with no done_spin.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN when enable=1 and opcode≠STOP. At that edge:
  - opcode and magnitude are latched;
  - accumulator and prescaler are cleared;
  - busy=1 and the motors drive from the next cycle on (1-cycle latency).
- STOP opcode in IDLE: remain in IDLE.
- RUN:
  - Prescaler counts 0..TICK_DIV-1. At the terminal count, accumulator += output_speed, saturating at 2^ACC_W-1.
  - When accumulator ≥ latched magnitude (zero-extended) → DONE on the next edge. A magnitude of 0 reaches DONE after exactly one RUN cycle.
  - Changes to motion_command during RUN are ignored; the latched values are used.
  - output_speed=0: PWMs stay low and the accumulator does not advance. The block stays in RUN (no timeout).
  - enable=0 → IDLE at that edge: abort, no done_spin, motors off.
- DONE:
  - done_spin=1, busy=0, PWMs 0.
  - Hold until enable=0 or motion_command ≠ latched command (opcode+magnitude), then → IDLE.
  - The new command is not accepted on the DONE→IDLE edge. It is accepted at the earliest one cycle later.
- Simultaneous events in RUN: enable low in the same cycle as the completion condition → IDLE (abort wins).
- PWM:
  - 3-bit free-running pwm_cnt runs in RUN only and is cleared otherwise.
  - pwm_out = (pwm_cnt < output_speed). Speed 7 gives a 7/8 duty; speed 0 gives 0.
  - pwm_cnt wraps 7→0.
- Direction outputs (registered, valid while busy; both 0 when not busy):
  - FWD: left_dir=1, right_dir=1, both PWMs driven.
  - SPIN_L: left_dir=0, right_dir=1.
  - SPIN_R: left_dir=1, right_dir=0.
- All outputs are registered.

Decomposition:
- Shared package:
  - opcode localparams OP_STOP/OP_FWD/OP_SPIN_L/OP_SPIN_R;
  - field slices CMD_OP_MSB/LSB and CMD_MAG_MSB/LSB;
  - state encoding.
- The package is reused by spiral_move for command encoding.
- One sub-module: motor_pwm (3-bit counter plus compare, instanced twice or shared counter with two comparators). Prescaler and FSM stay in the top.

Test Plan:
Run with TICK_DIV=4, ACC_W=11.
1. Reset: hold rst=0 for 2 clocks with the command 10_00001000 applied → all outputs 0. Release; the cycle after the edge, busy=1, left_dir=0, right_dir=1.
2. SPIN_L, magnitude=8, speed=4, enable=1 → accumulator reaches 8 after 2 ticks (8 cycles). done_spin rises on the next edge and stays high. Change the command to 00_00000000 → IDLE next cycle, done_spin=0.
3. FWD, magnitude=0, speed=7 → busy for exactly 1 cycle, then done_spin=1. PWM high 7 of every 8 RUN cycles (RUN too short to observe; repeat with magnitude=255 and check duty over 64 cycles = 56 high).
4. SPIN_R, magnitude=20, speed=5; drop enable after 6 cycles → IDLE the next edge, no done_spin pulse, PWMs 0, busy 0.
5. Speed=0 during RUN for 40 cycles → accumulator frozen, PWMs 0, busy stays 1. Speed back to 3 → completes at the computed tick.
6. Command change mid-RUN (SPIN_L,8 → FWD,200) → completion uses magnitude 8 and dirs stay SPIN_L. In DONE, the differing command returns the FSM to IDLE, then FWD,200 is accepted one cycle later.
